// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, data width and the four
// SPI mode codes ({cpol, cpha}) used by both the master and slave side.
package spi_pkg;

  localparam int SPI_DW = 8;
  localparam int SPI_BW = $clog2(SPI_DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CP0  = 2'd1,
    CP1  = 2'd2
  } spi_state_e;

  // Mode code is {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic mode_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter for the SPI master. Raises tick on the last cycle
// of every CLK_DIV-cycle half-period while en is high; clears when en=0
// so every transfer starts with a full-length first half-period.
module spi_clk_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  // CLK_DIV=1 would give a zero-width counter, so keep at least one bit
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count up while enabled, wrap at the end of each half-period
  always_comb begin
    cnt_d = cnt_q;
    if (!en || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == LAST);

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Byte-wide SPI master. Shifts tx_data out MSB-first on MOSI while
// capturing MISO, then pulses done with the received byte on rx_data.
// Optional macro SPI_MASTER_MODE_SEL_EN: when defined cpol/cpha select any
// of the four SPI modes; when undefined mode 0 is hard-wired.
// All outputs come straight from flops.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SPI_DW-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  output logic              ready,
  output logic              done,
  output logic [SPI_DW-1:0] rx_data,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SS
);

  localparam logic [SPI_BW-1:0] LAST_BIT = SPI_BW'(SPI_DW - 1);

  spi_state_e state_q, state_d;

  logic [SPI_DW-1:0] tx_sh_q, tx_sh_d;
  logic [SPI_DW-1:0] rx_sh_q, rx_sh_d;
  logic [SPI_BW-1:0] bit_cnt_q, bit_cnt_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;

  logic [SPI_DW-1:0] rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ss_q, ss_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic cpol_in, cpha_in;
  logic tick;
  logic accept;
  logic lead_edge;
  logic trail_edge;
  logic last_edge;

`ifdef SPI_MASTER_MODE_SEL_EN
  assign cpol_in = cpol;
  assign cpha_in = cpha;
`else
  // Mode pins remain on the port list but have no effect in this build
  logic unused_mode;
  assign unused_mode = cpol ^ cpha;
  assign cpol_in     = mode_cpol(SPI_MODE0);
  assign cpha_in     = mode_cpha(SPI_MODE0);
`endif

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state_q != IDLE),
    .tick  (tick)
  );

  // ready_q is high exactly when state_q is IDLE, so it doubles as the
  // idle qualifier for start
  assign accept     = start && ready_q;
  assign lead_edge  = (state_q == CP0) && tick;
  assign trail_edge = (state_q == CP1) && tick;
  assign last_edge  = trail_edge && (bit_cnt_q == LAST_BIT);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: each CP state lasts one full half-period
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CP0;
      CP0:     if (tick) state_d = CP1;
      CP1:     if (tick) state_d = (bit_cnt_q == LAST_BIT) ? IDLE : CP0;
      default: state_d = IDLE;
    endcase
  end

  // Shift/sample datapath; which edge samples and which edge shifts
  // depends on the latched cpha
  always_comb begin
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    bit_cnt_d = bit_cnt_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    rx_data_d = rx_data_q;
    if (accept) begin
      tx_sh_d   = tx_data;
      rx_sh_d   = '0;
      bit_cnt_d = '0;
      cpol_d    = cpol_in;
      cpha_d    = cpha_in;
    end
    if (lead_edge) begin
      if (!cpha_q) begin
        rx_sh_d = {rx_sh_q[SPI_DW-2:0], MISO};
      end else begin
        tx_sh_d = tx_sh_q << 1;
      end
    end
    if (trail_edge) begin
      if (cpha_q) begin
        rx_sh_d = {rx_sh_q[SPI_DW-2:0], MISO};
      end else if (!last_edge) begin
        tx_sh_d = tx_sh_q << 1;
      end
      if (!last_edge) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
    if (last_edge) begin
      rx_data_d = rx_sh_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      bit_cnt_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else begin
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      bit_cnt_q <= bit_cnt_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
    end
  end

  // FSM output logic, computed from the next state so the registered
  // bus pins line up with the state they belong to
  always_comb begin
    ss_d    = (state_d == IDLE);
    ready_d = (state_d == IDLE);
    done_d  = last_edge;
    sclk_d  = (state_d == CP1) ? ~cpol_d : cpol_d;
    mosi_d  = mosi_q;
    if (state_d == IDLE) begin
      mosi_d = 1'b0;
    end else if (!cpha_d) begin
      // cpha=0: current bit is on the wire for the whole bit period
      mosi_d = tx_sh_d[SPI_DW-1];
    end else if (lead_edge) begin
      // cpha=1: next bit is launched on the leading edge and held
      mosi_d = tx_sh_q[SPI_DW-1];
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign rx_data = rx_data_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;
  assign ready   = ready_q;
  assign done    = done_q;

endmodule
